shift_walk_ctrl: RTL and testbench

- Controller and checker for the 6-bit walking-one left-shift register.
- Drives the shifter's load, bit and clear inputs; reads back its parallel output every cycle.
- Verifies that the single 1 walks from bit 0 to the MSB and then falls off.
- Repeats for a configurable number of passes; reports position, pass count, done and error to the surrounding test/sequencer logic.

---
 rtl/shift_walk_pkg.sv | 20 ++
 rtl/onehot_enc.sv | 26 ++
 rtl/shift_walk_ctrl.sv | 154 +++++++++++++++
 tb/tb_shift_walk_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_walk_pkg.sv
// Shared types and constants for the walking-one shifter controller/checker.
package shift_walk_pkg;

   // Controller states; the encoding is fixed so that IDLE is all-zero.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      TRACK = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   // Error codes reported on err_code_out.
   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_ONEHOT = 2'd1;
   localparam logic [1:0] ERR_POS    = 2'd2;
   localparam logic [1:0] ERR_EXIT   = 2'd3;

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot encoder: index of the set bit plus a one-hot flag.
module onehot_enc #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned PW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] number,
   output logic [PW-1:0]    index,
   output logic             is_onehot
);

   // OR together the indices of all set bits; exact only when one-hot.
   always_comb begin
      index = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (number[i]) begin
            index = index | PW'(i);
         end
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   always_comb begin
      is_onehot = (number != '0) && ((number & (number - WIDTH'(1))) == '0);
   end

endmodule

// File: rtl/shift_walk_ctrl.sv
// Controller/checker for a walking-one left-shift register: loads a single 1,
// checks it walks bit 0..MSB and falls off, and repeats for PASSES walks.
module shift_walk_ctrl
   import shift_walk_pkg::*;
#(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned PASSES = 4,
   parameter int unsigned PW     = $clog2(WIDTH),
   parameter int unsigned CW     = $clog2(PASSES + 1)
) (
   input  logic             clk_in,
   input  logic             clr_n_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] number_in,
   output logic             sr_clr_out,
   output logic             load_out,
   output logic             bit1_out,
   output logic [PW-1:0]    pos_out,
   output logic             pos_valid_out,
   output logic [CW-1:0]    pass_cnt_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             err_out,
   output logic [1:0]       err_code_out
);

   // Expected-position counter must also hold WIDTH for the exit cycle.
   localparam int unsigned EW = $clog2(WIDTH + 1);

   state_t          state_q, state_d;
   logic [EW-1:0]   exp_q, exp_d;
   logic [CW-1:0]   pass_q, pass_d;
   logic [1:0]      code_q, code_d;

   logic [PW-1:0]   idx;
   logic            is_onehot;
   logic            at_exp;

   onehot_enc #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_enc (
      .number    (number_in),
      .index     (idx),
      .is_onehot (is_onehot)
   );

   // Set bit is exactly where the walk should be this cycle.
   always_comb begin
      at_exp = is_onehot && (EW'(idx) == exp_q);
   end

   // State and counter registers.
   always_ff @(posedge clk_in or negedge clr_n_in) begin
      if (!clr_n_in) begin
         state_q <= IDLE;
         exp_q   <= '0;
         pass_q  <= '0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         pass_q  <= pass_d;
         code_q  <= code_d;
      end
   end

   // Next-state, counter updates and Moore output decode.
   always_comb begin
      state_d       = state_q;
      exp_d         = exp_q;
      pass_d        = pass_q;
      code_d        = code_q;
      sr_clr_out    = 1'b0;
      load_out      = 1'b0;
      pos_valid_out = 1'b0;
      pos_out       = '0;
      busy_out      = 1'b0;
      done_out      = 1'b0;
      err_out       = 1'b0;

      case (state_q)
         IDLE: begin
            sr_clr_out = 1'b1;
            if (start_in) begin
               state_d = CLEAR;
               pass_d  = '0;
               code_d  = ERR_NONE;
            end
         end

         CLEAR: begin
            sr_clr_out = 1'b1;
            busy_out   = 1'b1;
            state_d    = LOAD;
         end

         LOAD: begin
            load_out = 1'b1;
            busy_out = 1'b1;
            exp_d    = '0;
            state_d  = TRACK;
         end

         TRACK: begin
            busy_out = 1'b1;
            if (exp_q < EW'(WIDTH)) begin
               if (at_exp) begin
                  pos_valid_out = 1'b1;
                  pos_out       = idx;
                  exp_d         = exp_q + EW'(1);
               end else begin
                  state_d = ERROR;
                  code_d  = is_onehot ? ERR_POS : ERR_ONEHOT;
               end
            end else if (number_in != '0) begin
               state_d = ERROR;
               code_d  = ERR_EXIT;
            end else begin
               pass_d  = pass_q + CW'(1);
               state_d = ((pass_q + CW'(1)) == CW'(PASSES)) ? DONE : LOAD;
            end
         end

         DONE: begin
            done_out = 1'b1;
            state_d  = IDLE;
         end

         ERROR: begin
            sr_clr_out = 1'b1;
            err_out    = 1'b1;
            if (start_in) begin
               state_d = CLEAR;
               pass_d  = '0;
               code_d  = ERR_NONE;
            end
         end

         default: begin
            sr_clr_out = 1'b1;
            state_d    = IDLE;
         end
      endcase
   end

   // The shifter's serial input is the load strobe itself.
   always_comb begin
      bit1_out     = load_out;
      pass_cnt_out = pass_q;
      err_code_out = code_q;
   end

endmodule

// File: tb/tb_shift_walk_ctrl.sv
// Bench for shift_walk_ctrl: a behavioural shifter wired to the controller,
// a timeline reference model, a checkpoint table and fault-injection sequences.
module tb_shift_walk_ctrl;

   localparam int unsigned W  = 6;
   localparam int unsigned P  = 4;
   localparam int unsigned PW = $clog2(W);
   localparam int unsigned CW = $clog2(P + 1);
   localparam int MI = 0, MR = 1, MD = 2, ME = 3;

   logic          clk;
   logic          clr_n_in;
   logic          start_in;
   logic [W-1:0]  number_in;
   logic          sr_clr_out, load_out, bit1_out, pos_valid_out;
   logic [PW-1:0] pos_out;
   logic [CW-1:0] pass_cnt_out;
   logic          busy_out, done_out, err_out;
   logic [1:0]    err_code_out;

   shift_walk_ctrl #(.WIDTH(W), .PASSES(P)) dut (
      .clk_in        (clk),
      .clr_n_in      (clr_n_in),
      .start_in      (start_in),
      .number_in     (number_in),
      .sr_clr_out    (sr_clr_out),
      .load_out      (load_out),
      .bit1_out      (bit1_out),
      .pos_out       (pos_out),
      .pos_valid_out (pos_valid_out),
      .pass_cnt_out  (pass_cnt_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .err_out       (err_out),
      .err_code_out  (err_code_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: mode plus cycle count since the start was accepted.
   int m_mode, m_t, m_pass, m_code;
   logic [W-1:0] shreg;

   // Output samples taken at the falling edge.
   int s_sr, s_load, s_bit, s_pv, s_pos, s_pass, s_busy, s_done, s_err, s_code;

   typedef struct {
      int k; int sr; int load; int pv; int pos; int pass; int busy; int done;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic sample();
      s_sr   = int'(sr_clr_out);
      s_load = int'(load_out);
      s_bit  = int'(bit1_out);
      s_pv   = int'(pos_valid_out);
      s_pos  = int'(pos_out);
      s_pass = int'(pass_cnt_out);
      s_busy = int'(busy_out);
      s_done = int'(done_out);
      s_err  = int'(err_out);
      s_code = int'(err_code_out);
   endtask

   // Expected outputs from the run timeline: cycle 1 is CLEAR, then each pass
   // is W+2 cycles (load, W positions, exit).
   task automatic check_model();
      int e_sr, e_load, e_pv, e_pos, e_pass, e_busy, e_done, e_err, e_code;
      int u, p, r;
      logic [W-1:0] want;
      e_sr = 0; e_load = 0; e_pv = 0; e_pos = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_pass = m_pass; e_code = m_code;
      case (m_mode)
         MI: e_sr = 1;
         MR: begin
            e_busy = 1; e_code = 0;
            if (m_t == 1) begin
               e_sr = 1; e_pass = 0;
            end else begin
               u = m_t - 2; p = u / (W + 2); r = u % (W + 2);
               e_pass = p;
               if (r == 0) e_load = 1;
               else if (r <= W) begin
                  want = '0; want[r-1] = 1'b1;
                  if (number_in == want) begin e_pv = 1; e_pos = r - 1; end
               end
            end
         end
         MD: begin e_done = 1; e_pass = P; end
         default: begin e_err = 1; e_sr = 1; end
      endcase
      chk("sr_clr", s_sr, e_sr);
      chk("load", s_load, e_load);
      chk("bit1", s_bit, e_load);
      chk("pos_valid", s_pv, e_pv);
      chk("pos", s_pos, e_pos);
      chk("pass_cnt", s_pass, e_pass);
      chk("busy", s_busy, e_busy);
      chk("done", s_done, e_done);
      chk("err", s_err, e_err);
      chk("err_code", s_code, e_code);
   endtask

   // Advance the model across one clock edge given this cycle's inputs.
   task automatic model_step(input logic st, input logic [W-1:0] num);
      int u, p, r;
      logic [W-1:0] want;
      case (m_mode)
         MI, ME: if (st) begin m_mode = MR; m_t = 1; m_pass = 0; m_code = 0; end
         MD: m_mode = MI;
         default: begin
            if (m_t == 1) m_t = 2;
            else begin
               u = m_t - 2; p = u / (W + 2); r = u % (W + 2);
               if (r == 0) m_t++;
               else if (r <= W) begin
                  want = '0; want[r-1] = 1'b1;
                  if (num == want) m_t++;
                  else begin
                     m_mode = ME; m_pass = p;
                     m_code = ($countones(num) == 1) ? 2 : 1;
                  end
               end else if (num != '0) begin
                  m_mode = ME; m_pass = p; m_code = 3;
               end else if (p + 1 == P) begin
                  m_mode = MD; m_pass = P;
               end else m_t++;
            end
         end
      endcase
   endtask

   // One clock cycle: drive inputs, check at the falling edge, clock the model
   // and the shifter. Optionally corrupt number_in or pulse reset mid-cycle.
   task automatic cycle(input logic st, input bit cor, input logic [W-1:0] cv, input bit rst);
      start_in  = st;
      number_in = cor ? cv : shreg;
      if (rst) begin
         #2;
         clr_n_in = 1'b0;
         m_mode = MI; m_t = 0; m_pass = 0; m_code = 0;
      end
      @(negedge clk);
      sample();
      check_model();
      if (clr_n_in) model_step(st, number_in);
      @(posedge clk);
      #1;
      shreg = (s_sr != 0) ? '0 : {shreg[W-2:0], (s_load != 0) && (s_bit != 0)};
      clr_n_in = 1'b1;
   endtask

   task automatic norm(input logic st);
      cycle(st, 1'b0, '0, 1'b0);
   endtask

   int done_cnt;
   int busy35, busy36;

   initial begin
      tbl[0]  = '{1,  1, 0, 0, 0, 0, 1, 0};
      tbl[1]  = '{2,  0, 1, 0, 0, 0, 1, 0};
      tbl[2]  = '{3,  0, 0, 1, 0, 0, 1, 0};
      tbl[3]  = '{8,  0, 0, 1, 5, 0, 1, 0};
      tbl[4]  = '{9,  0, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{10, 0, 1, 0, 0, 1, 1, 0};
      tbl[6]  = '{12, 0, 0, 1, 1, 1, 1, 0};
      tbl[7]  = '{27, 0, 0, 1, 0, 3, 1, 0};
      tbl[8]  = '{33, 0, 0, 0, 0, 3, 1, 0};
      tbl[9]  = '{34, 0, 0, 0, 0, 4, 0, 1};
      tbl[10] = '{35, 1, 0, 0, 0, 4, 0, 0};

      clr_n_in = 1'b0; start_in = 1'b0; number_in = '0; shreg = '0;
      m_mode = MI; m_t = 0; m_pass = 0; m_code = 0;

      // Reset values.
      @(negedge clk);
      sample();
      chk("rst_sr_clr", s_sr, 1);
      chk("rst_load", s_load, 0);
      chk("rst_bit1", s_bit, 0);
      chk("rst_pos_valid", s_pv, 0);
      chk("rst_pos", s_pos, 0);
      chk("rst_pass_cnt", s_pass, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
      chk("rst_err", s_err, 0);
      chk("rst_err_code", s_code, 0);
      @(posedge clk); #1;
      clr_n_in = 1'b1;
      norm(1'b0); norm(1'b0);

      // Nominal run against the checkpoint table.
      norm(1'b1);
      done_cnt = 0;
      for (int k = 1; k <= 35; k++) begin
         norm(1'b0);
         if (s_done != 0) done_cnt++;
         for (int i = 0; i < 11; i++) begin
            if (tbl[i].k == k) begin
               chk($sformatf("tbl_k%0d_sr_clr", k), s_sr, tbl[i].sr);
               chk($sformatf("tbl_k%0d_load", k), s_load, tbl[i].load);
               chk($sformatf("tbl_k%0d_pos_valid", k), s_pv, tbl[i].pv);
               chk($sformatf("tbl_k%0d_pos", k), s_pos, tbl[i].pos);
               chk($sformatf("tbl_k%0d_pass_cnt", k), s_pass, tbl[i].pass);
               chk($sformatf("tbl_k%0d_busy", k), s_busy, tbl[i].busy);
               chk($sformatf("tbl_k%0d_done", k), s_done, tbl[i].done);
            end
         end
      end
      chk("nom_done_pulses", done_cnt, 1);

      // Stuck bit in the second tracking cycle, then recovery by a new start.
      norm(1'b1);
      for (int k = 1; k <= 3; k++) norm(1'b0);
      cycle(1'b0, 1'b1, 6'b000011, 1'b0);
      norm(1'b0);
      chk("stuck_err", s_err, 1);
      chk("stuck_code", s_code, 1);
      chk("stuck_busy", s_busy, 0);
      chk("stuck_sr_clr", s_sr, 1);
      norm(1'b0);
      chk("stuck_sticky", s_err, 1);
      norm(1'b1);
      done_cnt = 0;
      for (int k = 1; k <= 35; k++) begin
         norm(1'b0);
         if (s_done != 0) done_cnt++;
      end
      chk("recover_done_pulses", done_cnt, 1);
      chk("recover_err", s_err, 0);
      chk("recover_pass_cnt", s_pass, P);

      // Skipped position in the second pass.
      norm(1'b1);
      for (int k = 1; k <= 11; k++) norm(1'b0);
      cycle(1'b0, 1'b1, 6'b000100, 1'b0);
      norm(1'b0);
      chk("skip_code", s_code, 2);
      chk("skip_pass_cnt", s_pass, 1);
      norm(1'b0); norm(1'b0);
      chk("skip_pass_frozen", s_pass, 1);

      // Set bit still present in the exit cycle.
      norm(1'b1);
      for (int k = 1; k <= 8; k++) norm(1'b0);
      cycle(1'b0, 1'b1, 6'b100000, 1'b0);
      norm(1'b0);
      chk("exit_code", s_code, 3);
      chk("exit_pass_cnt", s_pass, 0);

      // Reset during the second pass: immediate IDLE and no done pulse.
      norm(1'b1);
      for (int k = 1; k <= 12; k++) norm(1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("midrst_busy", s_busy, 0);
      chk("midrst_sr_clr", s_sr, 1);
      chk("midrst_pass_cnt", s_pass, 0);
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         norm(1'b0);
         if (s_done != 0) done_cnt++;
      end
      chk("midrst_no_done", done_cnt, 0);

      // Start held high: ignored while busy/DONE, retaken after one IDLE cycle.
      norm(1'b1);
      done_cnt = 0; busy35 = -1; busy36 = -1;
      for (int k = 1; k <= 36; k++) begin
         norm(1'b1);
         if (s_done != 0) done_cnt++;
         if (k == 35) busy35 = s_busy;
         if (k == 36) busy36 = s_busy;
      end
      chk("held_first_done", done_cnt, 1);
      chk("held_idle_gap", busy35, 0);
      chk("held_restart", busy36, 1);
      done_cnt = 0;
      for (int k = 37; k <= 70; k++) begin
         norm(1'b0);
         if (s_done != 0) done_cnt++;
      end
      chk("held_second_done", done_cnt, 1);

      // Random starts, corruptions and resets against the model.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
               W'($urandom), ($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
